divider: RTL and testbench
==========================

Name: divider

Overview:
- Fully pipelined unsigned restoring divider: one quotient bit resolved per stage; accepts one dividend/divisor pair per cycle.
- Carries a filter-index sideband tag (k) alongside each operation.
- Sits in the filter index decoder; `F` instances run in parallel. Each instance converts a linear weight sequence number into a quotient/remainder, from which the parent derives row/col position.
- A global stall freezes the whole pipeline.

Parameters:
- N, default 8: dividend width in bits.
- M, default 4: divisor and remainder width in bits.
- N_ACT, default M+N-1: internal working width; quotient width is N_ACT-M+1 (= N).
- KW, default 4: width of the k sideband tag ($clog2(Kc)+1 in the parent).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-low.
- data_rdy  input  1  operand valid; pair is accepted on a non-stalled edge when high.
- dividend  input  N  unsigned dividend.
- divisor  input  M  unsigned divisor.
- k_in  input  KW  sideband tag travelling with the operands.
- stall  input  1  when high, all pipeline registers hold.
- res_rdy  output  1  result valid.
- quotient  output  N_ACT-M+1  floor(dividend/divisor).
- remainder  output  M  dividend mod divisor.
- k_out  output  KW  k_in of the operation currently presented.

Behaviour:
- Pipeline has S = N_ACT-M+1 stages. Each stage holds:
  - a valid bit,
  - partial remainder (M+1 bits),
  - remaining dividend bits,
  - quotient bits so far,
  - divisor copy,
  - k tag.
- Stage i computes quotient bit N-1-i, MSB first:
  - shift the partial remainder left and bring in the next dividend bit;
  - if the result >= divisor: subtract divisor and set the q bit to 1; otherwise set it to 0.
- Latency: a pair accepted at edge t appears on the outputs after edge t+S-1, with res_rdy=1. There is no output register beyond stage S.
- Throughput: one result per non-stalled cycle; valids, data and tags move in lockstep.
- stall=1: every stage register, including valid bits, holds. Inputs are ignored. Outputs keep their current values.
- data_rdy=0 on a non-stalled edge: a bubble (valid=0) enters stage 0. Data fields are don't-care; zero them for determinism.
- Reset (rst=0, asynchronous, at any time including mid-operation):
  - all valid bits cleared; all data and tag fields cleared;
  - outputs res_rdy=0, quotient=0, remainder=0, k_out=0;
  - in-flight operations are discarded.
- Outputs are driven directly from the last stage registers, so quotient, remainder and k_out are valid only while res_rdy=1.
- Divisor = 0:
  - quotient = all ones;
  - remainder = low M bits of dividend;
  - res_rdy still asserts after the normal latency.
- Dividend = 0: quotient 0, remainder 0.
- Dividend < divisor: quotient 0, remainder = dividend.
- All arithmetic is unsigned. Remainder is always < divisor when divisor != 0.
- The parent treats a remainder of 0 specially (col = divisor); the divider itself performs no such mapping.

Optional Feature:
- Macro DIVIDER_OUT_REG_EN.
- Defined:
  - one extra register stage after stage S; latency becomes S+1;
  - the extra stage obeys stall and reset exactly like the others;
  - outputs are fully registered.
- Undefined: outputs come straight from stage S; latency is S.

Test Plan:
- Reset: hold rst=0 with random inputs -> res_rdy=0, quotient=0, remainder=0, k_out=0. Release and apply dividend=13, divisor=3, k_in=2 with data_rdy=1 for one cycle -> after S cycles: res_rdy=1, quotient=4, remainder=1, k_out=2 for exactly one cycle.
- Back-to-back operations, one pair per cycle: (9,3,k=1), (10,3,k=1), (18,9,k=2), (0,5,k=3) -> consecutive results (3,0,1), (3,1,1), (2,0,2), (0,0,3) with no gaps.
- Stall: hold stall=1 for 3 cycles while two operations are in flight -> outputs frozen during the stall. After release, results emerge in order with their latency extended by exactly 3.
- Edge cases:
  - divisor=0, dividend=7 -> quotient all ones, remainder=7;
  - dividend=255, divisor=15 (N=8, M=4) -> quotient=17, remainder=0;
  - dividend=2, divisor=5 -> quotient=0, remainder=2.
- Asynchronous reset mid-pipeline: assert rst=0 between clock edges with 3 operations in flight -> res_rdy drops immediately. No stale result appears after release.
- Randomized: 1000 random pairs with random data_rdy/stall -> every result matches a golden model (floor division and mod) in order, with correct k_out.

Source files
------------

// File: rtl/divider.sv
// Pipelined unsigned restoring divider that resolves one quotient bit per stage and carries a k tag.
// Optional macro DIVIDER_OUT_REG_EN adds one registered output stage, so latency grows by one.
module divider #(
    parameter int unsigned N     = 8,
    parameter int unsigned M     = 4,
    parameter int unsigned N_ACT = M + N - 1,
    parameter int unsigned KW    = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               data_rdy,
    input  logic [N-1:0]       dividend,
    input  logic [M-1:0]       divisor,
    input  logic [KW-1:0]      k_in,
    input  logic               stall,
    output logic               res_rdy,
    output logic [N_ACT-M:0]   quotient,
    output logic [M-1:0]       remainder,
    output logic [KW-1:0]      k_out
);

    localparam int unsigned S  = N_ACT - M + 1;
    localparam int unsigned QW = S;
    localparam int unsigned RW = M + 1;

    logic            r_vld [S];
    logic [RW-1:0]   r_rem [S];
    logic [N-1:0]    r_dvd [S];
    logic [QW-1:0]   r_quo [S];
    logic [M-1:0]    r_dvs [S];
    logic [KW-1:0]   r_k   [S];

    logic            w_in_vld [S];
    logic [RW-1:0]   w_in_rem [S];
    logic [N-1:0]    w_in_dvd [S];
    logic [QW-1:0]   w_in_quo [S];
    logic [M-1:0]    w_in_dvs [S];
    logic [KW-1:0]   w_in_k   [S];

    logic [RW-1:0]   w_shift   [S];
    logic            w_ge      [S];
    logic [RW-1:0]   w_rem_nxt [S];
    logic [N-1:0]    w_dvd_nxt [S];
    logic [QW-1:0]   w_quo_nxt [S];

    // Stage inputs: stage 0 takes the ports, and a bubble enters with its data zeroed.
    always_comb begin
        w_in_vld[0] = data_rdy;
        w_in_rem[0] = '0;
        w_in_quo[0] = '0;
        w_in_dvd[0] = data_rdy ? dividend : '0;
        w_in_dvs[0] = data_rdy ? divisor  : '0;
        w_in_k[0]   = data_rdy ? k_in     : '0;
        for (int i = 1; i < int'(S); i++) begin
            w_in_vld[i] = r_vld[i-1];
            w_in_rem[i] = r_rem[i-1];
            w_in_quo[i] = r_quo[i-1];
            w_in_dvd[i] = r_dvd[i-1];
            w_in_dvs[i] = r_dvs[i-1];
            w_in_k[i]   = r_k[i-1];
        end
    end

    // One restoring step per stage. A zero divisor always subtracts, which yields all-ones and low dividend bits.
    always_comb begin
        for (int i = 0; i < int'(S); i++) begin
            w_shift[i]   = RW'({w_in_rem[i], w_in_dvd[i][N-1]});
            w_ge[i]      = (w_shift[i] >= RW'(w_in_dvs[i]));
            w_rem_nxt[i] = w_ge[i] ? (w_shift[i] - RW'(w_in_dvs[i])) : w_shift[i];
            w_dvd_nxt[i] = w_in_dvd[i] << 1;
            w_quo_nxt[i] = (w_in_quo[i] << 1) | QW'(w_ge[i]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(S); i++) begin
                r_vld[i] <= 1'b0;
                r_rem[i] <= '0;
                r_dvd[i] <= '0;
                r_quo[i] <= '0;
                r_dvs[i] <= '0;
                r_k[i]   <= '0;
            end
        end else if (!stall) begin
            for (int i = 0; i < int'(S); i++) begin
                r_vld[i] <= w_in_vld[i];
                r_rem[i] <= w_rem_nxt[i];
                r_dvd[i] <= w_dvd_nxt[i];
                r_quo[i] <= w_quo_nxt[i];
                r_dvs[i] <= w_in_dvs[i];
                r_k[i]   <= w_in_k[i];
            end
        end
    end

`ifdef DIVIDER_OUT_REG_EN
    logic            r_out_vld;
    logic [QW-1:0]   r_out_quo;
    logic [M-1:0]    r_out_rem;
    logic [KW-1:0]   r_out_k;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_vld <= 1'b0;
            r_out_quo <= '0;
            r_out_rem <= '0;
            r_out_k   <= '0;
        end else if (!stall) begin
            r_out_vld <= r_vld[S-1];
            r_out_quo <= r_quo[S-1];
            r_out_rem <= M'(r_rem[S-1]);
            r_out_k   <= r_k[S-1];
        end
    end

    assign res_rdy   = r_out_vld;
    assign quotient  = r_out_quo;
    assign remainder = r_out_rem;
    assign k_out     = r_out_k;
`else
    assign res_rdy   = r_vld[S-1];
    assign quotient  = r_quo[S-1];
    assign remainder = M'(r_rem[S-1]);
    assign k_out     = r_k[S-1];
`endif

endmodule

// File: tb/tb_divider.sv
// Bench for divider: a delay-line model built on plain arithmetic is checked every cycle, and directed literal checks run beside it.
module tb_divider;

    localparam int unsigned N     = 8;
    localparam int unsigned M     = 4;
    localparam int unsigned N_ACT = M + N - 1;
    localparam int unsigned KW    = 4;
    localparam int unsigned S     = N_ACT - M + 1;
    localparam int unsigned QW    = S;
`ifdef DIVIDER_OUT_REG_EN
    localparam int unsigned LAT   = S + 1;
`else
    localparam int unsigned LAT   = S;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            data_rdy;
    logic [N-1:0]    dividend;
    logic [M-1:0]    divisor;
    logic [KW-1:0]   k_in;
    logic            stall;
    logic            res_rdy;
    logic [QW-1:0]   quotient;
    logic [M-1:0]    remainder;
    logic [KW-1:0]   k_out;

    int checks   = 0;
    int errors   = 0;
    int accepted = 0;

    divider #(.N(N), .M(M), .N_ACT(N_ACT), .KW(KW)) dut (
        .clk       (clk),
        .rst       (rst),
        .data_rdy  (data_rdy),
        .dividend  (dividend),
        .divisor   (divisor),
        .k_in      (k_in),
        .stall     (stall),
        .res_rdy   (res_rdy),
        .quotient  (quotient),
        .remainder (remainder),
        .k_out     (k_out)
    );

    always #5 clk = ~clk;

    // Expected results travel through a LAT-deep line and are computed with / and %.
    logic            m_v [LAT];
    logic [QW-1:0]   m_q [LAT];
    logic [M-1:0]    m_r [LAT];
    logic [KW-1:0]   m_k [LAT];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(LAT); i++) begin
                m_v[i] = 1'b0; m_q[i] = '0; m_r[i] = '0; m_k[i] = '0;
            end
        end else if (!stall) begin
            for (int i = int'(LAT) - 1; i > 0; i--) begin
                m_v[i] = m_v[i-1]; m_q[i] = m_q[i-1]; m_r[i] = m_r[i-1]; m_k[i] = m_k[i-1];
            end
            m_v[0] = data_rdy;
            m_k[0] = k_in;
            if (divisor == 0) begin
                m_q[0] = '1;
                m_r[0] = dividend[M-1:0];
            end else begin
                m_q[0] = QW'(dividend / N'(divisor));
                m_r[0] = M'(dividend % N'(divisor));
            end
            if (data_rdy) accepted++;
        end
    end

    always @(negedge clk) begin
        checks++;
        if (!rst) begin
            if (res_rdy !== 1'b0 || quotient !== '0 || remainder !== '0 || k_out !== '0) begin
                errors++;
                $display("FAIL reset_outputs: got rdy=%b q=%0d r=%0d k=%0d required all zero",
                         res_rdy, quotient, remainder, k_out);
            end
        end else if (res_rdy !== m_v[LAT-1]) begin
            errors++;
            $display("FAIL model_res_rdy at %0t: got %b required %b", $time, res_rdy, m_v[LAT-1]);
        end else if (m_v[LAT-1] && (quotient !== m_q[LAT-1] || remainder !== m_r[LAT-1] || k_out !== m_k[LAT-1])) begin
            errors++;
            $display("FAIL model_result at %0t: got q=%0d r=%0d k=%0d required q=%0d r=%0d k=%0d",
                     $time, quotient, remainder, k_out, m_q[LAT-1], m_r[LAT-1], m_k[LAT-1]);
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, got, exp);
        end
    endtask

    task automatic check_out(input string name, input logic [31:0] q, input logic [31:0] r, input logic [31:0] k);
        check({name, "_rdy"}, 32'(res_rdy), 32'd1);
        check({name, "_q"}, 32'(quotient), q);
        check({name, "_r"}, 32'(remainder), r);
        check({name, "_k"}, 32'(k_out), k);
    endtask

    task automatic drive(input logic [N-1:0] a, input logic [M-1:0] b, input logic [KW-1:0] k);
        data_rdy = 1'b1; dividend = a; divisor = b; k_in = k;
        @(posedge clk); #1;
        data_rdy = 1'b0;
    endtask

    task automatic run_single(input string name, input logic [N-1:0] a, input logic [M-1:0] b,
                              input logic [KW-1:0] k, input logic [31:0] q, input logic [31:0] r);
        drive(a, b, k);
        repeat (LAT - 1) @(posedge clk);
        #1 check_out(name, q, r, 32'(k));
        @(posedge clk); #1 check({name, "_one_cycle"}, 32'(res_rdy), 32'd0);
    endtask

    initial begin
        int stale;
        int target;
        rst = 1'b0; data_rdy = 1'b0; stall = 1'b0;
        dividend = '0; divisor = '0; k_in = '0;

        // Random inputs while held in reset.
        repeat (5) begin
            @(posedge clk); #1;
            data_rdy = 1'($urandom); stall = 1'($urandom);
            dividend = N'($urandom); divisor = M'($urandom); k_in = KW'($urandom);
        end
        check("rst_rdy", 32'(res_rdy), 32'd0);
        check("rst_q", 32'(quotient), 32'd0);
        check("rst_r", 32'(remainder), 32'd0);
        check("rst_k", 32'(k_out), 32'd0);
        data_rdy = 1'b0; stall = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;

        run_single("basic", 8'd13, 4'd3, 4'd2, 32'd4, 32'd1);

        // Four operations back to back, then four consecutive results.
        data_rdy = 1'b1; dividend = 8'd9;  divisor = 4'd3; k_in = 4'd1; @(posedge clk); #1;
        dividend = 8'd10; divisor = 4'd3; k_in = 4'd1; @(posedge clk); #1;
        dividend = 8'd18; divisor = 4'd9; k_in = 4'd2; @(posedge clk); #1;
        dividend = 8'd0;  divisor = 4'd5; k_in = 4'd3; @(posedge clk); #1;
        data_rdy = 1'b0;
        repeat (LAT - 4) @(posedge clk);
        #1 check_out("b2b0", 32'd3, 32'd0, 32'd1);
        @(posedge clk); #1 check_out("b2b1", 32'd3, 32'd1, 32'd1);
        @(posedge clk); #1 check_out("b2b2", 32'd2, 32'd0, 32'd2);
        @(posedge clk); #1 check_out("b2b3", 32'd0, 32'd0, 32'd3);
        @(posedge clk); #1 check("b2b_end", 32'(res_rdy), 32'd0);

        // Three stalled cycles with two operations in flight.
        data_rdy = 1'b1; dividend = 8'd20; divisor = 4'd6; k_in = 4'd5; @(posedge clk); #1;
        dividend = 8'd15; divisor = 4'd4; k_in = 4'd6; @(posedge clk); #1;
        data_rdy = 1'b0; stall = 1'b1;
        repeat (3) @(posedge clk);
        #1 stall = 1'b0;
        repeat (LAT - 3) @(posedge clk);
        #1 check("stall_early", 32'(res_rdy), 32'd0);
        @(posedge clk); #1 check_out("stall0", 32'd3, 32'd2, 32'd5);
        @(posedge clk); #1 check_out("stall1", 32'd3, 32'd3, 32'd6);
        @(posedge clk); #1 check("stall_end", 32'(res_rdy), 32'd0);

        run_single("div0", 8'd7, 4'd0, 4'd7, 32'd255, 32'd7);
        run_single("max", 8'd255, 4'd15, 4'd8, 32'd17, 32'd0);
        run_single("small", 8'd2, 4'd5, 4'd9, 32'd0, 32'd2);

        // Asynchronous reset while the first of three results is showing.
        data_rdy = 1'b1; dividend = 8'd100; divisor = 4'd7; k_in = 4'd4; @(posedge clk); #1;
        dividend = 8'd50; divisor = 4'd6; k_in = 4'd5; @(posedge clk); #1;
        dividend = 8'd77; divisor = 4'd8; k_in = 4'd6; @(posedge clk); #1;
        data_rdy = 1'b0;
        repeat (LAT - 3) @(posedge clk);
        #1 check_out("pre_arst", 32'd14, 32'd2, 32'd4);
        #2 rst = 1'b0;
        #1 check("arst_rdy", 32'(res_rdy), 32'd0);
        check("arst_q", 32'(quotient), 32'd0);
        @(posedge clk); #1 rst = 1'b1;
        stale = 0;
        repeat (LAT + 3) begin
            @(posedge clk); #1;
            if (res_rdy) stale++;
        end
        check("no_stale", 32'(stale), 32'd0);

        // Random traffic with random bubbles and stalls.
        target = accepted + 1000;
        for (int cyc = 0; cyc < 20000 && accepted < target; cyc++) begin
            data_rdy = ($urandom_range(0, 3) != 0);
            stall    = ($urandom_range(0, 4) == 0);
            dividend = N'($urandom);
            divisor  = M'($urandom);
            k_in     = KW'($urandom);
            @(posedge clk); #1;
        end
        check("random_count", 32'(accepted >= target), 32'd1);
        data_rdy = 1'b0; stall = 1'b0;
        repeat (LAT + 2) @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
